// File: rtl/chunked_subtractor_pkg.sv
// Shared definitions for the chunked subtractor: FSM state encoding,
// default geometry, slice-count derivation and geometry sanity check.
package chunked_subtractor_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned CHUNK_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int unsigned nchunk(input int unsigned w, input int unsigned c);
    return w / c;
  endfunction

  // Geometry is legal only when WIDTH is a non-zero multiple of CHUNK.
  function automatic bit width_ok(input int unsigned w, input int unsigned c);
    return (c != 0) && (w >= c) && ((w % c) == 0);
  endfunction

  // Width of a counter/index able to address n items (at least 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_subtractor_sub_slice.sv
// Combinational CHUNK-bit subtract with borrow: {bout_o, d_o} = a_i - b_i - bin_i.
// Ports: a_i/b_i operand slices, bin_i borrow-in, d_o difference slice,
//        bout_o borrow-out, bmsb_o borrow into the slice MSB (for overflow).
module chunked_subtractor_sub_slice #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             bin_i,
  output logic [CHUNK-1:0] d_o,
  output logic             bout_o,
  output logic             bmsb_o
);

  logic [CHUNK:0] diff;

  assign diff   = {1'b0, a_i} - {1'b0, b_i} - (CHUNK + 1)'(bin_i);
  assign d_o    = diff[CHUNK-1:0];
  assign bout_o = diff[CHUNK];
  // MSB difference bit is a ^ b ^ borrow_in, so the borrow into it is recoverable.
  assign bmsb_o = diff[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor D = A - B - Bin, one CHUNK-bit slice per clock with a
// registered ripple borrow. Operands arrive on a valid/ready handshake and the
// result (D, Bout, Z, V) is held under a valid/ready handshake.
// Ports: clk/rst (sync, active-high); in_valid/in_ready, A, B, Bin input side;
//        out_valid/out_ready, D, Bout, Z, V result side.
module chunked_subtractor
  import chunked_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Z,
  output logic             V
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned KW     = idx_w(NCHUNK);
  localparam int unsigned IW     = idx_w(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_geometry
    $error("chunked_subtractor: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [KW-1:0]    k_q, k_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d, z_q, z_d, v_q, v_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [IW-1:0]    base;
  logic [CHUNK-1:0] s_d;
  logic             s_bout, s_bmsb;

  // Bit offset of the slice currently being processed.
  assign base = IW'(k_q * CHUNK);

  chunked_subtractor_sub_slice #(.CHUNK(CHUNK)) u_slice (
    .a_i    (a_q[base +: CHUNK]),
    .b_i    (b_q[base +: CHUNK]),
    .bin_i  (borrow_q),
    .d_o    (s_d),
    .bout_o (s_bout),
    .bmsb_o (s_bmsb)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    k_d      = k_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    z_d      = z_q;
    v_d      = v_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          k_d      = '0;
          d_d      = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        d_d[base +: CHUNK] = s_d;
        borrow_d           = s_bout;
        if (k_q == K_LAST) begin
          bout_d  = s_bout;
          v_d     = s_bmsb ^ s_bout;
          z_d     = (d_d == '0);
          state_d = ST_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      k_q         <= '0;
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      d_q         <= d_d;
      k_q         <= k_d;
      borrow_q    <= borrow_d;
      bout_q      <= bout_d;
      z_q         <= z_d;
      v_q         <= v_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign Bout      = bout_q;
  assign Z         = z_q;
  assign V         = v_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Self-checking bench for chunked_subtractor (64-bit, 16-bit chunks).
module tb_chunked_subtractor;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned CHUNK  = 16;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] A, B, D;
  logic        Bin, Bout, Z, V;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chunked_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .Z         (Z),
    .V         (V)
  );

  // Reference: plain wide arithmetic, signed range check for overflow.
  function automatic void ref_sub(input logic [63:0] a, input logic [63:0] b, input logic bin,
                                  output logic [63:0] d, output logic bout,
                                  output logic z, output logic v);
    logic [64:0]        u;
    logic signed [65:0] s;
    u    = {1'b0, a} - {1'b0, b} - 65'(bin);
    d    = u[63:0];
    bout = u[64];
    z    = (d == 64'd0);
    s    = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, bin});
    v    = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
  endfunction

  // Drive one operation, return observed result and accept-to-valid latency.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                        output logic [63:0] d, output logic bout, output logic z,
                        output logic v, output int lat, output bit ok);
    int w;
    ok = 1'b1;
    @(negedge clk);
    A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    if (!in_ready) ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!out_valid) ok = 1'b0;
    d = D; bout = Bout; z = Z; v = V;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (D !== 64'd0) begin n_err++; $display("FAIL reset_D got %h want 0", D); end
    n_vec++; if ({Bout, Z, V} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {Bout, Z, V}); end
  endtask

  task automatic test_directed();
    logic [63:0] ta [5] = '{64'd5, 64'd0, 64'h0000_0000_0001_0000, 64'd9, 64'h8000_0000_0000_0000};
    logic [63:0] tb [5] = '{64'd3, 64'd1, 64'd1, 64'd9, 64'd1};
    logic        tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] ed [5] = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFE, 64'd0,
                            64'h7FFF_FFFF_FFFF_FFFF};
    logic [2:0]  ef [5] = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b001};
    logic [63:0] d;
    logic        bo, z, v;
    int          lat;
    bit          ok;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tc[i], d, bo, z, v, lat, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL dir%0d_timeout got no result want result", i); end
      n_vec++; if (d !== ed[i]) begin n_err++; $display("FAIL dir%0d_D got %h want %h", i, d, ed[i]); end
      n_vec++; if ({bo, z, v} !== ef[i]) begin n_err++; $display("FAIL dir%0d_BoutZV got %b want %b", i, {bo, z, v}, ef[i]); end
      n_vec++; if (lat != NCHUNK) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, NCHUNK); end
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++; $display("FAIL dir%0d_return_idle got rdy=%b vld=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, d, ed;
    logic        bin, bo, z, v, ebo, ez, ev;
    int          lat;
    bit          ok;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = (i % 5 == 0) ? a : {$urandom, $urandom};
      if (i % 7 == 3) b = {b[63:32], 16'h0000, a[15:0]};
      bin = 1'($urandom_range(0, 1));
      ref_sub(a, b, bin, ed, ebo, ez, ev);
      run_op(a, b, bin, d, bo, z, v, lat, ok);
      n_vec++;
      if (!ok || d !== ed || {bo, z, v} !== {ebo, ez, ev}) begin
        n_err++;
        $display("FAIL rand%0d a=%h b=%h bin=%b got D=%h BZV=%b want D=%h BZV=%b",
                 i, a, b, bin, d, {bo, z, v}, ed, {ebo, ez, ev});
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    @(negedge clk);
    A = 64'd5; B = 64'd3; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    A = {$urandom, $urandom}; B = 64'd1;
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    n_vec++; if (!out_valid) begin n_err++; $display("FAIL bp_timeout got no out_valid want 1"); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (D !== 64'd2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold%0d got D=%h rdy=%b vld=%b want D=2 rdy=0 vld=1", i, D, in_ready, out_valid);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 64'd2) begin
      n_err++; $display("FAIL bp_release got rdy=%b vld=%b D=%h want 1 0 2", in_ready, out_valid, D);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    logic [63:0] d;
    logic        bo, z, v;
    int          lat;
    bit          ok, seen;
    @(negedge clk);
    A = 64'h1234_5678_9ABC_DEF0; B = 64'h0FED_CBA9_8765_4321; Bin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 64'd0 || {Bout, Z, V} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_values got rdy=%b vld=%b D=%h BZV=%b want 1 0 0 000",
                        in_ready, out_valid, D, {Bout, Z, V});
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL rst_mid_no_output got out_valid=1 want 0"); end
    run_op(64'd7, 64'd2, 1'b0, d, bo, z, v, lat, ok);
    n_vec++; if (!ok || d !== 64'd5 || {bo, z, v} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_follow got D=%h BZV=%b want D=5 BZV=000", d, {bo, z, v});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] qd [$];
    logic [2:0]  qf [$];
    int          acc [$];
    logic [63:0] a, b, ed;
    logic        bin, ebo, ez, ev;
    int          issued, got;
    issued = 0; got = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 80 && got < 4; t++) begin
      @(negedge clk);
      if (out_valid) begin
        n_vec++;
        if (qd.size() == 0) begin
          n_err++; $display("FAIL b2b_spurious got D=%h want no result", D);
        end else begin
          if (D !== qd[0] || {Bout, Z, V} !== qf[0]) begin
            n_err++; $display("FAIL b2b_result%0d got D=%h BZV=%b want D=%h BZV=%b",
                              got, D, {Bout, Z, V}, qd[0], qf[0]);
          end
          void'(qd.pop_front()); void'(qf.pop_front());
        end
        got++;
      end
      if (in_ready && issued < 4) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom_range(0, 1));
        ref_sub(a, b, bin, ed, ebo, ez, ev);
        qd.push_back(ed); qf.push_back({ebo, ez, ev}); acc.push_back(cyc);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        issued++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (got != 4) begin n_err++; $display("FAIL b2b_count got %0d want 4", got); end
    for (int i = 1; i < acc.size(); i++) begin
      n_vec++; if (acc[i] - acc[i-1] != int'(NCHUNK + 2)) begin
        n_err++; $display("FAIL b2b_interval%0d got %0d want %0d", i, acc[i] - acc[i-1], NCHUNK + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
